instr_encoder_loader: RTL and testbench
=======================================

Name: instr_encoder_loader

Overview:
Inverse of the opcode decoder. Accepts one instruction at a time as a one-hot instruction-class vector plus operand fields, and builds the 32-bit MIPS-style instruction word. Writes consecutive words into instruction memory through a simple write port. Used by the testbench/boot path to load programs into the single-cycle/multi-cycle datapath's instruction memory without a hex file.

Parameters:
DEPTH, 256, number of instruction words the loader may write per program (power of two)
AW, 8, memory word-address width, log2(DEPTH)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
start  input  1  one-cycle pulse; begins a program load at word address 0
finish  input  1  one-cycle pulse; ends the load after the pending write drains
in_valid  input  1  instruction request valid
in_ready  output  1  loader can accept a request this cycle
cls  input  10  one-hot class {RT, addi, andi, lw, sw, j, jal, jr, beq, bne}, bit 9 = RT
rs  input  5  source register field
rt  input  5  target register field
rd  input  5  destination register field (R-type only)
funct  input  6  function field (R-type only)
imm  input  16  immediate/offset (I-type)
target  input  26  jump target (J-type)
mem_we  output  1  instruction memory write enable
mem_addr  output  AW  word address of the write
mem_wdata  output  32  encoded instruction word
prog_len  output  AW+1  number of valid words written in the current/last load
err  output  1  sticky: an invalid class vector was received since start
done  output  1  one-cycle pulse when the load completes

Behaviour:
- Reset (sync, rst=1 at edge): state=IDLE; in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, prog_len=0, err=0, done=0. A reset mid-load aborts the load; a pending write is dropped; no done pulse.
- States:
  - IDLE: in_ready=0. start -> LOAD, clears prog_len and err.
  - LOAD: in_ready = (acc_cnt < DEPTH). Accept when in_valid && in_ready. finish -> DRAIN. acc_cnt == DEPTH after an accept -> FULL.
  - FULL: in_ready=0. finish -> DRAIN.
  - DRAIN: in_ready=0. When no write is pending: done=1 for 1 cycle, then -> IDLE.
  - start outside IDLE is ignored. If finish and an accept occur in the same cycle, the request is accepted and written before done.
- Encoding (opcodes must match the decoder exactly):
  - RT: {000000, rs, rt, rd, 5'b0, funct}
  - addi 001000, andi 001100, lw 100011, sw 101011, beq 000100, bne 000101: {opc, rs, rt, imm}
  - j 000010, jal 000011: {opc, target}
  - jr 110011: {opc, rs, 21'b0}
  - Fields not used by the class are ignored.
- Latency: a request accepted at edge N is registered into mem_wdata/mem_addr with mem_we=1 during cycle N+1. Throughput is 1 word/cycle with back-to-back acceptance.
- mem_addr equals the number of prior valid writes, starting at 0. prog_len increments on each mem_we and is held after done until the next start.
- Invalid class (zero bits or more than one bit set):
  - The request is consumed (handshake completes).
  - No write; acc_cnt and address do not advance.
  - err is set and stays set until start or rst.
- Full boundary: at most DEPTH words. The accept that makes acc_cnt=DEPTH writes address DEPTH-1; no wrap-around ever occurs. prog_len then equals DEPTH, which needs AW+1 bits.
- in_valid while in_ready=0 has no effect; the requester must hold the request until it is accepted.

Test Plan:
- Reset mid-load: accept 3 words, assert rst -> next cycle mem_we=0, prog_len=0, state IDLE, no done.
- Back-to-back encode: start, then addi rs=1 rt=2 imm=0x0005, then RT rs=1 rt=2 rd=3 funct=0x20 on consecutive cycles -> mem_wdata=0x20220005 @0, then 0x00221820 @1, mem_we high both cycles.
- Jump and jr encoding: j target=0x0000010 -> 0x08000010. jal target=0x3FFFFFF -> 0x0FFFFFFF. jr rs=31 -> 0xCFE00000.
- Invalid class: cls=10'b0 then cls=10'b0000010001 -> no mem_we, err=1, mem_addr unchanged. A following valid lw is written at the unchanged address.
- Full: DEPTH=4; send 6 valid requests -> 4 writes at addresses 0..3, in_ready=0 after the 4th accept, prog_len=4. finish -> done pulse.
- finish coincident with an accept of sw rs=29 rt=8 imm=0xFFFC -> 0xAFA8FFFC written, then done exactly one cycle after the write. start during DRAIN is ignored.

Source files
------------

// File: rtl/instr_encoder_loader.sv
// rtl/instr_encoder_loader.sv - encodes one-hot class + operand fields into 32-bit MIPS words and streams them into instruction memory
module instr_encoder_loader #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          finish,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [9:0]    cls,
    input  logic [4:0]    rs,
    input  logic [4:0]    rt,
    input  logic [4:0]    rd,
    input  logic [5:0]    funct,
    input  logic [15:0]   imm,
    input  logic [25:0]   target,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [AW:0]   prog_len,
    output logic          err,
    output logic          done
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        FULL,
        DRAIN
    } state_t;

    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] LAST_CNT  = (AW+1)'(DEPTH - 1);

    localparam logic [5:0] OPC_RT   = 6'b000000;
    localparam logic [5:0] OPC_ADDI = 6'b001000;
    localparam logic [5:0] OPC_ANDI = 6'b001100;
    localparam logic [5:0] OPC_LW   = 6'b100011;
    localparam logic [5:0] OPC_SW   = 6'b101011;
    localparam logic [5:0] OPC_J    = 6'b000010;
    localparam logic [5:0] OPC_JAL  = 6'b000011;
    localparam logic [5:0] OPC_JR   = 6'b110011;
    localparam logic [5:0] OPC_BEQ  = 6'b000100;
    localparam logic [5:0] OPC_BNE  = 6'b000101;

    state_t      state;
    logic [AW:0] acc_cnt;
    logic        accept;
    logic        cls_ok;
    logic [31:0] word;

    assign in_ready = (state == LOAD) && (acc_cnt < DEPTH_CNT);
    assign accept   = in_valid && in_ready;

    // Exactly one class bit set; anything else is consumed but flagged.
    assign cls_ok = (cls != 10'd0) && ((cls & (cls - 10'd1)) == 10'd0);

    always_comb begin
        word = 32'd0;
        if (cls[9])      word = {OPC_RT, rs, rt, rd, 5'd0, funct};
        else if (cls[8]) word = {OPC_ADDI, rs, rt, imm};
        else if (cls[7]) word = {OPC_ANDI, rs, rt, imm};
        else if (cls[6]) word = {OPC_LW, rs, rt, imm};
        else if (cls[5]) word = {OPC_SW, rs, rt, imm};
        else if (cls[4]) word = {OPC_J, target};
        else if (cls[3]) word = {OPC_JAL, target};
        else if (cls[2]) word = {OPC_JR, rs, 21'd0};
        else if (cls[1]) word = {OPC_BEQ, rs, rt, imm};
        else if (cls[0]) word = {OPC_BNE, rs, rt, imm};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc_cnt   <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 32'd0;
            prog_len  <= '0;
            err       <= 1'b0;
            done      <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= LOAD;
                        acc_cnt  <= '0;
                        prog_len <= '0;
                        err      <= 1'b0;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        if (cls_ok) begin
                            mem_we    <= 1'b1;
                            mem_addr  <= acc_cnt[AW-1:0];
                            mem_wdata <= word;
                            acc_cnt   <= acc_cnt + 1'b1;
                            prog_len  <= acc_cnt + 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                    if (finish)
                        state <= DRAIN;
                    else if (accept && cls_ok && acc_cnt == LAST_CNT)
                        state <= FULL;
                end
                FULL: begin
                    if (finish)
                        state <= DRAIN;
                end
                DRAIN: begin
                    // The last write is already on the port this cycle, so it
                    // commits at this edge and done follows it directly.
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb/tb_instr_encoder_loader.sv - directed self-checking bench for instr_encoder_loader
module tb_instr_encoder_loader;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    localparam logic [9:0] C_RT   = 10'b1000000000;
    localparam logic [9:0] C_ADDI = 10'b0100000000;
    localparam logic [9:0] C_LW   = 10'b0001000000;
    localparam logic [9:0] C_SW   = 10'b0000100000;
    localparam logic [9:0] C_J    = 10'b0000010000;
    localparam logic [9:0] C_JAL  = 10'b0000001000;
    localparam logic [9:0] C_JR   = 10'b0000000100;

    logic          clk = 1'b0;
    logic          rst, start, finish, in_valid;
    logic          in_ready;
    logic [9:0]    cls;
    logic [4:0]    rs, rt, rd;
    logic [5:0]    funct;
    logic [15:0]   imm;
    logic [25:0]   target;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [AW:0]   prog_len;
    logic          err, done;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    instr_encoder_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .finish(finish),
        .in_valid(in_valid), .in_ready(in_ready), .cls(cls),
        .rs(rs), .rt(rt), .rd(rd), .funct(funct), .imm(imm), .target(target),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .prog_len(prog_len), .err(err), .done(done)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [9:0] c, input logic [4:0] s, input logic [4:0] t,
                       input logic [4:0] d, input logic [5:0] f, input logic [15:0] i,
                       input logic [25:0] tg);
        in_valid = 1'b1;
        cls = c; rs = s; rt = t; rd = d; funct = f; imm = i; target = tg;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; finish = 1'b0; in_valid = 1'b0;
        cls = '0; rs = '0; rt = '0; rd = '0; funct = '0; imm = '0; target = '0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_in_ready", in_ready, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_prog_len", prog_len, 0);
        check("rst_err", err, 0);
        check("rst_done", done, 0);

        // back-to-back encode then reset mid-load
        pulse_start();
        check("load_in_ready", in_ready, 1);
        req(C_ADDI, 5'd1, 5'd2, 5'd0, 6'd0, 16'h0005, 26'd0);
        tick();
        check("addi_we", mem_we, 1);
        check("addi_addr", mem_addr, 0);
        check("addi_word", mem_wdata, 32'h20220005);
        req(C_RT, 5'd1, 5'd2, 5'd3, 6'h20, 16'h0, 26'd0);
        tick();
        check("rt_we", mem_we, 1);
        check("rt_addr", mem_addr, 1);
        check("rt_word", mem_wdata, 32'h00221820);
        req(C_J, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0, 26'h0000010);
        tick();
        in_valid = 1'b0;
        check("j_addr", mem_addr, 2);
        check("j_word", mem_wdata, 32'h08000010);
        check("j_prog_len", prog_len, 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_we", mem_we, 0);
        check("midrst_prog_len", prog_len, 0);
        check("midrst_in_ready", in_ready, 0);
        check("midrst_done", done, 0);
        tick();
        check("midrst_done2", done, 0);
        check("midrst_idle", in_ready, 0);

        // jal / jr encoding, invalid classes, recovery
        pulse_start();
        req(C_JAL, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0, 26'h3FFFFFF);
        tick();
        check("jal_word", mem_wdata, 32'h0FFFFFFF);
        req(C_JR, 5'd31, 5'd7, 5'd9, 6'h3f, 16'hffff, 26'h1);
        tick();
        check("jr_word", mem_wdata, 32'hCFE00000);
        check("jr_addr", mem_addr, 1);
        req(10'b0, 5'd1, 5'd1, 5'd1, 6'd1, 16'h1, 26'h1);
        tick();
        check("inv0_we", mem_we, 0);
        check("inv0_err", err, 1);
        check("inv0_in_ready", in_ready, 1);
        req(10'b0000010001, 5'd1, 5'd1, 5'd1, 6'd1, 16'h1, 26'h1);
        tick();
        check("inv2_we", mem_we, 0);
        check("inv2_addr", mem_addr, 1);
        check("inv2_prog_len", prog_len, 2);
        req(C_LW, 5'd4, 5'd5, 5'd0, 6'd0, 16'h0010, 26'd0);
        tick();
        in_valid = 1'b0;
        check("lw_we", mem_we, 1);
        check("lw_addr", mem_addr, 2);
        check("lw_word", mem_wdata, 32'h8C850010);
        check("lw_err_sticky", err, 1);
        finish = 1'b1;
        tick();
        finish = 1'b0;
        check("fin_done_early", done, 0);
        tick();
        check("fin_done", done, 1);
        tick();
        check("fin_done_pulse", done, 0);
        check("fin_prog_len_held", prog_len, 3);
        check("fin_err_held", err, 1);

        // full boundary with DEPTH=4
        pulse_start();
        check("full_err_clr", err, 0);
        check("full_len_clr", prog_len, 0);
        for (int k = 0; k < 6; k++) begin
            req(C_ADDI, 5'd1, 5'd2, 5'd0, 6'd0, 16'(k), 26'd0);
            tick();
            if (k < 4) begin
                check($sformatf("full_we%0d", k), mem_we, 1);
                check($sformatf("full_addr%0d", k), mem_addr, 64'(k));
                check($sformatf("full_word%0d", k), mem_wdata, 64'(32'h20220000 + k));
            end else begin
                check($sformatf("full_nowe%0d", k), mem_we, 0);
            end
            if (k >= 3)
                check($sformatf("full_ready%0d", k), in_ready, 0);
        end
        in_valid = 1'b0;
        check("full_prog_len", prog_len, 4);
        check("full_addr_hold", mem_addr, 3);
        finish = 1'b1;
        tick();
        finish = 1'b0;
        tick();
        check("full_done", done, 1);

        // finish coincident with accept; start during DRAIN ignored
        pulse_start();
        req(C_SW, 5'd29, 5'd8, 5'd0, 6'd0, 16'hFFFC, 26'd0);
        finish = 1'b1;
        tick();
        in_valid = 1'b0;
        finish = 1'b0;
        check("sw_we", mem_we, 1);
        check("sw_addr", mem_addr, 0);
        check("sw_word", mem_wdata, 32'hAFA8FFFC);
        check("sw_done_early", done, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("sw_done", done, 1);
        check("sw_we_off", mem_we, 0);
        check("sw_prog_len", prog_len, 1);
        tick();
        check("drain_start_ignored", in_ready, 0);
        check("drain_done_off", done, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
